// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage placed between register read and execute. A 32-bit MIPS
// instruction and its register-file read data are decoded into the ALU's
// operation code, operands A/B, shift amount and write-back destination. The
// decoded payload is registered behind a 2-entry skid buffer. Both sides use
// valid/ready handshakes, and a synchronous flush is provided.
//
// Optional feature, enabled by defining ALU_ISSUE_STATS_EN:
//   o_issue_cnt   - 32-bit wrapping count of drained entries
//   o_illegal_cnt - 16-bit saturating count of drained illegal entries
//   Both counters are cleared only by i_reset (a flush leaves them alone).
//
// Ports:
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_valid / o_ready       upstream handshake
//   i_instr                 instruction word
//   i_rs_data, i_rt_data    register file read data for rs / rt
//   i_flush                 discard every buffered entry
//   o_valid / i_ready       downstream (ALU/execute) handshake
//   o_alu_op                ALU operation code (all ones = idle)
//   o_data_a, o_data_b      operands
//   o_shamt                 shift amount
//   o_dest, o_reg_write     write-back register and enable
//   o_illegal               unsupported instruction flag
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_instr,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [4:0]         o_shamt,
    output logic [NB_REG-1:0]  o_dest,
    output logic               o_reg_write,
    output logic               o_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]        o_issue_cnt,
    output logic [15:0]        o_illegal_cnt
`endif
);

    // Decoded payload carried by each buffer entry.
    typedef struct packed {
        logic [NB_OP-1:0]   alu_op;
        logic [NB_DATA-1:0] data_a;
        logic [NB_DATA-1:0] data_b;
        logic [4:0]         shamt;
        logic [NB_REG-1:0]  dest;
        logic               reg_write;
        logic               illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [NB_OP-1:0] ALU_OP_IDLE = {NB_OP{1'b1}};

    // Payload presented when nothing has been decoded yet or the instruction
    // is unsupported: idle opcode, everything else cleared.
    function automatic entry_t idle_entry(input logic illegal);
        entry_t e;
        e.alu_op    = ALU_OP_IDLE;
        e.data_a    = {NB_DATA{1'b0}};
        e.data_b    = {NB_DATA{1'b0}};
        e.shamt     = 5'd0;
        e.dest      = {NB_REG{1'b0}};
        e.reg_write = 1'b0;
        e.illegal   = illegal;
        return e;
    endfunction

    // R-type function codes the ALU implements.
    function automatic logic is_legal_funct(input logic [5:0] funct);
        logic legal;
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Full instruction decode into one buffer entry.
    function automatic entry_t decode_instr(
        input logic [NB_DATA-1:0] instr,
        input logic [NB_DATA-1:0] rs_data,
        input logic [NB_DATA-1:0] rt_data
    );
        entry_t     e;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [4:0] rs_field;
        opcode   = instr[31:26];
        funct    = instr[5:0];
        // rs is read through i_rs_data; the field is only kept so every
        // instruction bit has a consumer in the decode.
        rs_field = instr[25:21];
        e        = idle_entry(1'b1);
        if ((opcode == 6'h00) && is_legal_funct(funct)) begin
            e.alu_op  = NB_OP'(funct);
            e.data_b  = rt_data;
            e.shamt   = instr[10:6];
            e.dest    = NB_REG'(instr[15:11]);
            e.illegal = 1'b0;
            // Variable shifts only look at the low five bits of rs.
            if ((funct == 6'h04) || (funct == 6'h06) || (funct == 6'h07)) begin
                e.data_a      = {NB_DATA{1'b0}};
                e.data_a[4:0] = rs_data[4:0] | (rs_field & 5'd0);
            end else begin
                e.data_a = rs_data;
            end
        end else if (opcode[5:3] == 3'b001) begin
            e.alu_op  = NB_OP'(opcode);
            e.dest    = NB_REG'(instr[20:16]);
            e.shamt   = 5'd0;
            e.illegal = 1'b0;
            // 0x08-0x0B sign-extend the immediate, 0x0C-0x0F zero-extend it.
            if (opcode[2] == 1'b0) begin
                e.data_b = {{(NB_DATA-16){instr[15]}}, instr[15:0]};
            end else begin
                e.data_b = {{(NB_DATA-16){1'b0}}, instr[15:0]};
            end
            // LUI builds its result from B alone.
            if (opcode == 6'h0F) begin
                e.data_a = {NB_DATA{1'b0}};
            end else begin
                e.data_a = rs_data;
            end
        end else begin
            e = idle_entry(1'b1);
        end
        e.reg_write = (!e.illegal) && (e.dest != {NB_REG{1'b0}});
        return e;
    endfunction

    state_t state_r;
    entry_t main_r;
    entry_t skid_r;
    logic   valid_r;
    logic   ready_r;
    entry_t dec_s;
    logic   accept_s;
    logic   drain_s;

    // Combinational decode of the incoming instruction.
    always_comb begin
        dec_s = decode_instr(i_instr, i_rs_data, i_rt_data);
    end

    // Handshake qualifiers.
    always_comb begin
        accept_s = i_valid & ready_r;
        drain_s  = valid_r & i_ready;
    end

    // Skid-buffer state machine. main_r is always the entry on the outputs;
    // skid_r only holds the younger entry while in ST_TWO.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            main_r  <= idle_entry(1'b0);
            skid_r  <= idle_entry(1'b0);
        end else if (i_flush) begin
            // Flush wins over any accept or drain in the same cycle.
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r  <= dec_s;
                        state_r <= ST_ONE;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !drain_s) begin
                        skid_r  <= dec_s;
                        state_r <= ST_TWO;
                        ready_r <= 1'b0;
                    end else if (accept_s && drain_s) begin
                        main_r  <= dec_s;
                        state_r <= ST_ONE;
                    end else if (drain_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        main_r  <= skid_r;
                        state_r <= ST_ONE;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        o_ready     = ready_r;
        o_valid     = valid_r;
        o_alu_op    = main_r.alu_op;
        o_data_a    = main_r.data_a;
        o_data_b    = main_r.data_b;
        o_shamt     = main_r.shamt;
        o_dest      = main_r.dest;
        o_reg_write = main_r.reg_write;
        o_illegal   = main_r.illegal;
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] issue_cnt_r;
    logic [15:0] illegal_cnt_r;

    // Drain statistics; a drain in a flush cycle still reaches execute, so
    // it is counted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            issue_cnt_r   <= 32'd0;
            illegal_cnt_r <= 16'd0;
        end else if (drain_s) begin
            issue_cnt_r <= issue_cnt_r + 32'd1;
            if (main_r.illegal && (illegal_cnt_r != 16'hFFFF)) begin
                illegal_cnt_r <= illegal_cnt_r + 16'd1;
            end else begin
                illegal_cnt_r <= illegal_cnt_r;
            end
        end else begin
            issue_cnt_r   <= issue_cnt_r;
            illegal_cnt_r <= illegal_cnt_r;
        end
    end

    // Counter outputs.
    always_comb begin
        o_issue_cnt   = issue_cnt_r;
        o_illegal_cnt = illegal_cnt_r;
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed self-checking bench for alu_issue_stage. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge. Expected
// values are hand-computed from the instruction encodings.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_alu_op;
    logic [31:0] o_data_a;
    logic [31:0] o_data_b;
    logic [4:0]  o_shamt;
    logic [4:0]  o_dest;
    logic        o_reg_write;
    logic        o_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] o_issue_cnt;
    logic [15:0] o_illegal_cnt;
`endif

    int n_checks;
    int n_errors;

    alu_issue_stage #(
        .NB_OP   (6),
        .NB_DATA (32),
        .NB_REG  (5)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instr       (i_instr),
        .i_rs_data     (i_rs_data),
        .i_rt_data     (i_rt_data),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_alu_op      (o_alu_op),
        .o_data_a      (o_data_a),
        .o_data_b      (o_data_b),
        .o_shamt       (o_shamt),
        .o_dest        (o_dest),
        .o_reg_write   (o_reg_write),
        .o_illegal     (o_illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .o_issue_cnt   (o_issue_cnt),
        .o_illegal_cnt (o_illegal_cnt)
`endif
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for exactly one rising edge, then sample.
    task automatic push(input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt);
        @(negedge clk);
        i_valid   = 1'b1;
        i_instr   = instr;
        i_rs_data = rs;
        i_rt_data = rt;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Advance one cycle with no new upstream traffic, then sample.
    task automatic idle_cycle();
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across a rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_instr   = 32'd0;
        i_rs_data = 32'd0;
        i_rt_data = 32'd0;
        i_flush   = 1'b0;
        i_ready   = 1'b1;

        // Reset state.
        #12;
        check_value("rst_valid",  {31'd0, o_valid},  32'd0);
        check_value("rst_ready",  {31'd0, o_ready},  32'd1);
        check_value("rst_alu_op", {26'd0, o_alu_op}, 32'h3F);
        check_value("rst_data_a", o_data_a,          32'd0);
        check_value("rst_dest",   {27'd0, o_dest},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add $3,$1,$2 issues one cycle after accept.
        push(32'h00221820, 32'd5, 32'd7);
        check_value("add_valid",   {31'd0, o_valid},     32'd1);
        check_value("add_op",      {26'd0, o_alu_op},    32'h20);
        check_value("add_a",       o_data_a,             32'd5);
        check_value("add_b",       o_data_b,             32'd7);
        check_value("add_dest",    {27'd0, o_dest},      32'd3);
        check_value("add_wr",      {31'd0, o_reg_write}, 32'd1);
        check_value("add_illegal", {31'd0, o_illegal},   32'd0);

        // addi: sign-extended immediate.
        push(32'h2024FFFF, 32'h11, 32'd0);
        check_value("addi_op",   {26'd0, o_alu_op}, 32'h08);
        check_value("addi_a",    o_data_a,          32'h11);
        check_value("addi_b",    o_data_b,          32'hFFFFFFFF);
        check_value("addi_dest", {27'd0, o_dest},   32'd4);

        // ori: zero-extended immediate.
        push(32'h3424FFFF, 32'h11, 32'd0);
        check_value("ori_op", {26'd0, o_alu_op}, 32'h0D);
        check_value("ori_b",  o_data_b,          32'h0000FFFF);

        // lui $4,0x1234: operand A forced to zero.
        push(32'h3C041234, 32'hDEADBEEF, 32'd0);
        check_value("lui_op", {26'd0, o_alu_op}, 32'h0F);
        check_value("lui_a",  o_data_a,          32'd0);
        check_value("lui_b",  o_data_b,          32'h00001234);

        // sllv $5,$6,$7: A keeps only rs[4:0].
        push(32'h00E62804, 32'h00000023, 32'h0000000F);
        check_value("sllv_op",   {26'd0, o_alu_op}, 32'h04);
        check_value("sllv_a",    o_data_a,          32'h00000003);
        check_value("sllv_b",    o_data_b,          32'h0000000F);
        check_value("sllv_dest", {27'd0, o_dest},   32'd5);

        // sra $9,$8,7: shamt taken from instr[10:6].
        push(32'h000849C3, 32'd0, 32'h80000000);
        check_value("sra_op",    {26'd0, o_alu_op}, 32'h03);
        check_value("sra_shamt", {27'd0, o_shamt},  32'd7);
        check_value("sra_dest",  {27'd0, o_dest},   32'd9);

        // nop word issues as SLL without write-back.
        push(32'h00000000, 32'd1, 32'd2);
        check_value("nop_op",      {26'd0, o_alu_op},    32'h00);
        check_value("nop_wr",      {31'd0, o_reg_write}, 32'd0);
        check_value("nop_illegal", {31'd0, o_illegal},   32'd0);

        // slti $0,$0,5: legal but writes $0, so no write-back.
        push(32'h28000005, 32'd1, 32'd2);
        check_value("slti0_op", {26'd0, o_alu_op},    32'h0A);
        check_value("slti0_wr", {31'd0, o_reg_write}, 32'd0);

        // lw is unsupported.
        push(32'h8C220000, 32'd9, 32'd9);
        check_value("lw_illegal", {31'd0, o_illegal},   32'd1);
        check_value("lw_op",      {26'd0, o_alu_op},    32'h3F);
        check_value("lw_wr",      {31'd0, o_reg_write}, 32'd0);
        check_value("lw_a",       o_data_a,             32'd0);

        // jr (funct 0x08) is an unsupported R-type funct.
        push(32'h03E00008, 32'd9, 32'd9);
        check_value("jr_illegal", {31'd0, o_illegal}, 32'd1);
        check_value("jr_op",      {26'd0, o_alu_op},  32'h3F);

        idle_cycle();
        check_value("drained_empty", {31'd0, o_valid}, 32'd0);

        // Backpressure: I0 and I1 fill the buffer, I2 is held upstream.
        i_ready = 1'b0;
        push(32'h00221820, 32'h100, 32'd0);   // I0 add
        check_value("bp_i0_valid", {31'd0, o_valid},  32'd1);
        check_value("bp_i0_ready", {31'd0, o_ready},  32'd1);
        push(32'h00221822, 32'h101, 32'd0);   // I1 sub
        check_value("bp_i1_ready", {31'd0, o_ready},  32'd0);
        check_value("bp_hold_op",  {26'd0, o_alu_op}, 32'h20);
        @(negedge clk);
        i_valid   = 1'b1;                     // I2 and
        i_instr   = 32'h00221824;
        i_rs_data = 32'h102;
        @(posedge clk);
        #1;
        check_value("bp_i2_blocked", {31'd0, o_ready}, 32'd0);
        check_value("bp_hold_a",     o_data_a,         32'h100);
        @(negedge clk);
        i_ready = 1'b1;                       // I0 drains at the next edge
        @(posedge clk);
        #1;
        check_value("bp_out_i1_op", {26'd0, o_alu_op}, 32'h22);
        check_value("bp_out_i1_a",  o_data_a,          32'h101);
        check_value("bp_reopen",    {31'd0, o_ready},  32'd1);
        @(posedge clk);                       // I2 accepted while I1 drains
        #1;
        i_valid = 1'b0;
        check_value("bp_out_i2_op", {26'd0, o_alu_op}, 32'h24);
        check_value("bp_out_i2_a",  o_data_a,          32'h102);
        idle_cycle();
        check_value("bp_done", {31'd0, o_valid}, 32'd0);

        // Flush while full, together with a new instruction.
        i_ready = 1'b0;
        push(32'h00221825, 32'h200, 32'd0);
        push(32'h00221826, 32'h201, 32'd0);
        check_value("fl_full", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        i_valid   = 1'b1;
        i_flush   = 1'b1;
        i_instr   = 32'h00221827;
        i_rs_data = 32'h202;
        @(posedge clk);
        #1;
        check_value("fl_valid", {31'd0, o_valid}, 32'd0);
        check_value("fl_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        idle_cycle();
        idle_cycle();
        check_value("fl_none_issued", {31'd0, o_valid}, 32'd0);

        // Reset in the middle of a transfer discards the entry.
        i_ready = 1'b0;
        push(32'h00221820, 32'd5, 32'd7);
        check_value("mr_pre_valid", {31'd0, o_valid}, 32'd1);
        do_reset();
        check_value("mr_valid",  {31'd0, o_valid},  32'd0);
        check_value("mr_ready",  {31'd0, o_ready},  32'd1);
        check_value("mr_alu_op", {26'd0, o_alu_op}, 32'h3F);
        check_value("mr_data_b", o_data_b,          32'd0);

`ifdef ALU_ISSUE_STATS_EN
        // Drain 3 legal and 2 illegal entries.
        i_ready = 1'b1;
        push(32'h00221820, 32'd1, 32'd1);
        push(32'h8C220000, 32'd1, 32'd1);
        push(32'h2024FFFF, 32'd1, 32'd1);
        push(32'h03E00008, 32'd1, 32'd1);
        push(32'h3424FFFF, 32'd1, 32'd1);
        idle_cycle();
        check_value("st_issue",   o_issue_cnt,           32'd5);
        check_value("st_illegal", {16'd0, o_illegal_cnt}, 32'd2);
        // Flush without drain leaves counts alone.
        i_ready = 1'b0;
        push(32'h8C220000, 32'd1, 32'd1);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        i_flush = 1'b0;
        check_value("st_fl_issue",   o_issue_cnt,           32'd5);
        check_value("st_fl_illegal", {16'd0, o_illegal_cnt}, 32'd2);
        do_reset();
        check_value("st_rst_issue",   o_issue_cnt,           32'd0);
        check_value("st_rst_illegal", {16'd0, o_illegal_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
